alu_issue_ctrl: RTL and testbench

Multi-cycle instruction issue controller that drives the ALU operand/mode/enable interface. It decodes a 32-bit ALU instruction, reads source operands from an internal 32x32 register file, presents them to the ALU, captures the result, and writes it back. One instruction is in flight at a time, with a valid/ready handshake on the instruction input.

---
 rtl/alu_issue_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle issue controller for an external ALU.
// It decodes one 32-bit instruction at a time, reads its operands from a
// 32x32 register file, runs one ALU enable cycle, captures the result and
// writes it back.
//
// Optional feature macro: ALU_ISSUE_ILLEGAL_TRAP_EN
//   defined   - an illegal mode parks the controller in HALT until reset
//   undefined - an illegal mode is dropped after a one-cycle illegal pulse
//
// state  | meaning
// -------+-----------------------------------------------------------------
// s_idle | instr_ready=1, waiting for instr_valid; the instruction is latched
// s_read | operands and mode are read and latched; the mode is legality-checked
// s_exec | alu_en=1 for exactly one cycle; alu_result is captured
// s_wb   | wb_valid=1; R[rd] is written on the edge that leaves this state
// s_halt | (trap build only) illegal held high, only rst_n leaves this state

module alu_issue_ctrl #(
    parameter int NREGS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [3:0]  alu_mode,
    output logic        alu_en,
    input  logic [31:0] alu_result,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        illegal,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    localparam logic [3:0] MODE_MAX = 4'd10;

`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
    typedef enum logic [2:0] {
        s_idle = 3'd0,
        s_read = 3'd1,
        s_exec = 3'd2,
        s_wb   = 3'd3,
        s_halt = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        s_idle = 3'd0,
        s_read = 3'd1,
        s_exec = 3'd2,
        s_wb   = 3'd3
    } state_t;
`endif

    state_t      state;
    state_t      state_nxt;

    logic [31:0] instr_q;
    logic [31:0] result_q;
    logic [31:0] regs [NREGS];

    // instruction fields, always taken from the latched word
    logic [3:0]  f_mode;
    logic        f_imm_sel;
    logic [4:0]  f_rd;
    logic [4:0]  f_rs;
    logic [4:0]  f_rt;
    logic [16:0] f_imm17;
    logic        mode_legal;
    logic [31:0] op1_rd;
    logic [31:0] op2_rd;
    logic        accept;

    assign f_mode     = instr_q[31:28];
    assign f_imm_sel  = instr_q[27];
    assign f_rd       = instr_q[26:22];
    assign f_rs       = instr_q[21:17];
    assign f_rt       = instr_q[16:12];
    assign f_imm17    = instr_q[16:0];
    assign mode_legal = (f_mode <= MODE_MAX);

    // R0 is never written, so it already reads as zero; the explicit
    // compare keeps that true even if the array were ever preloaded.
    assign op1_rd = (f_rs == 5'd0) ? 32'd0 : regs[f_rs];
    assign op2_rd = f_imm_sel ? {{15{f_imm17[16]}}, f_imm17}
                              : ((f_rt == 5'd0) ? 32'd0 : regs[f_rt]);

    assign accept   = (state == s_idle) && instr_valid;
    assign dbg_data = (dbg_addr == 5'd0) ? 32'd0 : regs[dbg_addr];

    // write-back fields come straight from the latched instruction/result,
    // both of which reset to zero
    assign wb_rd   = f_rd;
    assign wb_data = result_q;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= s_idle;
        end else begin
            state <= state_nxt;
        end
    end

    // instruction latch on the accepting handshake edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= 32'd0;
        end else if (accept) begin
            instr_q <= instr;
        end
    end

    // ALU operand/mode registers: loaded in READ, held everywhere else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op1  <= 32'd0;
            alu_op2  <= 32'd0;
            alu_mode <= 4'd0;
        end else if (state == s_read && mode_legal) begin
            alu_op1  <= op1_rd;
            alu_op2  <= op2_rd;
            alu_mode <= f_mode;
        end
    end

    // ALU result capture at the end of the single EXEC cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= 32'd0;
        end else if (state == s_exec) begin
            result_q <= alu_result;
        end
    end

    // register file: cleared by reset, written on the edge that leaves WB;
    // a reset during WB wins, so an aborted instruction never writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= 32'd0;
            end
        end else if (state == s_wb && f_rd != 5'd0) begin
            regs[f_rd] <= result_q;
        end
    end

    // next-state and per-state control outputs
    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        alu_en      = 1'b0;
        wb_valid    = 1'b0;
        illegal     = 1'b0;
        case (state)
            s_idle: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    state_nxt = s_read;
                end
            end
            s_read: begin
                if (mode_legal) begin
                    state_nxt = s_exec;
                end else begin
                    illegal = 1'b1;
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
                    state_nxt = s_halt;
`else
                    state_nxt = s_idle;
`endif
                end
            end
            s_exec: begin
                alu_en    = 1'b1;
                state_nxt = s_wb;
            end
            s_wb: begin
                wb_valid  = 1'b1;
                state_nxt = s_idle;
            end
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
            s_halt: begin
                illegal   = 1'b1;
                state_nxt = s_halt;
            end
`endif
            default: begin
                state_nxt = s_idle;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl: a behavioural ALU answers alu_en cycles,
// a vector table of instructions with hand-computed results is issued and
// checked cycle by cycle, then the illegal-mode and reset-abort sequences.

module tb_alu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [3:0]  alu_mode;
    logic        alu_en;
    logic [31:0] alu_result;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        illegal;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int errors = 0;
    int checks = 0;
    int en_cnt = 0;
    int wb_cnt = 0;

    alu_issue_ctrl #(.NREGS(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .alu_op1     (alu_op1),
        .alu_op2     (alu_op2),
        .alu_mode    (alu_mode),
        .alu_en      (alu_en),
        .alu_result  (alu_result),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural ALU
    always_comb begin
        case (alu_mode)
            4'd0:    alu_result = alu_op1 + alu_op2;
            4'd1:    alu_result = alu_op1 - alu_op2;
            4'd2:    alu_result = alu_op1 & alu_op2;
            4'd3:    alu_result = alu_op1 | alu_op2;
            4'd4:    alu_result = alu_op1 ^ alu_op2;
            4'd5:    alu_result = ~alu_op1;
            4'd6:    alu_result = alu_op1 << alu_op2;
            4'd8:    alu_result = $signed(alu_op1) >>> alu_op2;
            4'd9:    alu_result = alu_op1 >> alu_op2;
            default: alu_result = 32'd0;
        endcase
    end

    // count enable and write-back cycles so per-instruction totals can be checked
    always @(posedge clk) begin
        if (alu_en) en_cnt++;
        if (wb_valid) wb_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [3:0]  mode;
        logic        imm_sel;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [16:0] low;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [31:0] enc(input logic [3:0] mode, input logic imm_sel,
                                        input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [16:0] low);
        return {mode, imm_sel, rd, rs, low};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (instr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", {31'd0, instr_ready}, 32'd1);
    endtask

    task automatic check_reg(input string nm, input logic [4:0] a, input logic [31:0] exp);
        dbg_addr = a;
        #1;
        chk(nm, dbg_data, exp);
    endtask

    // issue one instruction at a negedge and follow it through every state
    task automatic run_instr(input string nm, input logic [31:0] ins, input bit legal,
                             input logic [31:0] exp_wb);
        int en0;
        int wb0;
        wait_ready();
        en0 = en_cnt;
        wb0 = wb_cnt;
        instr       = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        // READ; a second request here must be ignored
        instr       = enc(4'd0, 1'b1, 5'd31, 5'd0, 17'h00123);
        chk({nm, "_read_ready"}, {31'd0, instr_ready}, 32'd0);
        chk({nm, "_read_en"}, {31'd0, alu_en}, 32'd0);
        chk({nm, "_read_illegal"}, {31'd0, illegal}, {31'd0, !legal});
        @(negedge clk);
        instr_valid = 1'b0;
        if (legal) begin
            chk({nm, "_exec_en"}, {31'd0, alu_en}, 32'd1);
            chk({nm, "_exec_mode"}, {28'd0, alu_mode}, {28'd0, ins[31:28]});
            chk({nm, "_exec_ready"}, {31'd0, instr_ready}, 32'd0);
            @(negedge clk);
            chk({nm, "_wb_valid"}, {31'd0, wb_valid}, 32'd1);
            chk({nm, "_wb_rd"}, {27'd0, wb_rd}, {27'd0, ins[26:22]});
            chk({nm, "_wb_data"}, wb_data, exp_wb);
            chk({nm, "_wb_en"}, {31'd0, alu_en}, 32'd0);
            @(negedge clk);
            chk({nm, "_idle_ready"}, {31'd0, instr_ready}, 32'd1);
            chk({nm, "_idle_wb"}, {31'd0, wb_valid}, 32'd0);
            chk({nm, "_en_cycles"}, en_cnt - en0, 32'd1);
            chk({nm, "_wb_cycles"}, wb_cnt - wb0, 32'd1);
        end else begin
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
            for (int k = 0; k < 6; k++) begin
                chk({nm, "_halt_illegal"}, {31'd0, illegal}, 32'd1);
                chk({nm, "_halt_ready"}, {31'd0, instr_ready}, 32'd0);
                chk({nm, "_halt_en"}, {31'd0, alu_en}, 32'd0);
                @(negedge clk);
            end
`else
            // back in IDLE two edges after acceptance
            chk({nm, "_idle_ready"}, {31'd0, instr_ready}, 32'd1);
            chk({nm, "_idle_illegal"}, {31'd0, illegal}, 32'd0);
            @(negedge clk);
`endif
            chk({nm, "_en_cycles"}, en_cnt - en0, 32'd0);
            chk({nm, "_wb_cycles"}, wb_cnt - wb0, 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_op1"}, alu_op1, 32'd0);
        chk({nm, "_op2"}, alu_op2, 32'd0);
        chk({nm, "_mode"}, {28'd0, alu_mode}, 32'd0);
        chk({nm, "_en"}, {31'd0, alu_en}, 32'd0);
        chk({nm, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
        chk({nm, "_wb_rd"}, {27'd0, wb_rd}, 32'd0);
        chk({nm, "_wb_data"}, wb_data, 32'd0);
        chk({nm, "_illegal"}, {31'd0, illegal}, 32'd0);
        chk({nm, "_ready"}, {31'd0, instr_ready}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{"addi_r1",   4'd0, 1'b1, 5'd1,  5'd0, 17'h1FFFF, 32'hFFFFFFFF};
        vecs[1] = '{"add_r2",    4'd0, 1'b0, 5'd2,  5'd1, {5'd1, 12'd0}, 32'hFFFFFFFE};
        vecs[2] = '{"addi_r7",   4'd0, 1'b1, 5'd7,  5'd0, 17'h00001, 32'h00000001};
        vecs[3] = '{"sll_r3",    4'd6, 1'b1, 5'd3,  5'd7, 17'h0001F, 32'h80000000};
        vecs[4] = '{"sra_r4",    4'd8, 1'b1, 5'd4,  5'd3, 17'h00004, 32'hF8000000};
        vecs[5] = '{"srl_r5",    4'd9, 1'b1, 5'd5,  5'd3, 17'h00004, 32'h08000000};
        vecs[6] = '{"or_r0",     4'd3, 1'b1, 5'd0,  5'd0, 17'h00005, 32'h00000005};
        vecs[7] = '{"not_r8",    4'd5, 1'b0, 5'd8,  5'd5, {5'd3, 12'd0}, 32'hF7FFFFFF};
        vecs[8] = '{"sub_r9",    4'd1, 1'b0, 5'd9,  5'd2, {5'd1, 12'd0}, 32'hFFFFFFFF};
        vecs[9] = '{"addi_r10",  4'd0, 1'b1, 5'd10, 5'd7, 17'h10000, 32'hFFFF0001};

        rst_n       = 1'b0;
        instr       = 32'd0;
        instr_valid = 1'b0;
        dbg_addr    = 5'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("in_reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset");
        for (int a = 0; a < 32; a++) begin
            check_reg($sformatf("reset_r%0d", a), a[4:0], 32'd0);
        end

        for (int v = 0; v < 10; v++) begin
            run_instr(vecs[v].name,
                      enc(vecs[v].mode, vecs[v].imm_sel, vecs[v].rd, vecs[v].rs, vecs[v].low),
                      1'b1, vecs[v].exp);
            check_reg({vecs[v].name, "_dbg"}, vecs[v].rd,
                      (vecs[v].rd == 5'd0) ? 32'd0 : vecs[v].exp);
        end
        check_reg("r1_kept", 5'd1, 32'hFFFFFFFF);
        check_reg("r31_not_written", 5'd31, 32'd0);

        // illegal mode 4'b1100 targeting R2: no ALU cycle, no write
        run_instr("illegal_c", enc(4'b1100, 1'b1, 5'd2, 5'd1, 17'h00001), 1'b0, 32'd0);
        check_reg("illegal_r2_kept", 5'd2, 32'hFFFFFFFE);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("halt_exit");
`else
        // the controller accepts again straight away
        run_instr("after_illegal", enc(4'd2, 1'b0, 5'd11, 5'd1, {5'd4, 12'd0}), 1'b1, 32'hF8000000);
        check_reg("after_illegal_dbg", 5'd11, 32'hF8000000);
`endif

        // reset during EXEC of R6 = 0x1234 aborts the write
        wait_ready();
        instr       = enc(4'd0, 1'b1, 5'd6, 5'd0, 17'h01234);
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk("abort_exec_en", {31'd0, alu_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_wb_cycles", {31'd0, wb_valid}, 32'd0);
        check_reg("abort_r6", 5'd6, 32'd0);
        check_reg("abort_r2_cleared", 5'd2, 32'd0);
        run_instr("reissue_r6", enc(4'd0, 1'b1, 5'd6, 5'd0, 17'h01234), 1'b1, 32'h00001234);
        check_reg("reissue_r6_dbg", 5'd6, 32'h00001234);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
